// File: rtl/fifo_axis_reader.sv
// Reads a packet of pkt_words words from a synchronous FIFO and streams them out
// as an AXI-Stream packet through a two-entry skid buffer.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  pkt_words,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_read_e,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    input  logic                  fifo_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_reg;
    logic [CNT_WIDTH-1:0]  pkt_len_reg;
    logic [CNT_WIDTH-1:0]  reads_left_reg;
    logic [CNT_WIDTH-1:0]  cap_idx_reg;
    logic                  read_pending_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // Output slot drives the stream; the skid slot absorbs a word that lands
    // while the output slot is stalled.
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic                  skid_valid_reg;
    logic                  skid_last_reg;

    logic                  pop;
    logic                  push;
    logic                  cap_last;
    logic [1:0]            load;
    logic                  room;
    logic                  read_en;

    assign pop      = out_valid_reg & m_axis_tready;
    assign push     = read_pending_reg;
    assign cap_last = (cap_idx_reg == (pkt_len_reg - CNT_ONE));

    // Words held plus the word in flight must leave space for one more read.
    assign load    = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(read_pending_reg);
    assign room    = (load < 2'd2) | (pop & (load == 2'd2));
    assign read_en = (state_reg == STREAM) & fifo_ready & ~fifo_empty &
                     (reads_left_reg != CNT_ZERO) & room;

    assign fifo_read_e   = read_en;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tlast  = out_last_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            pkt_len_reg      <= '0;
            reads_left_reg   <= '0;
            cap_idx_reg      <= '0;
            read_pending_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            out_data_reg     <= '0;
            out_valid_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
            skid_data_reg    <= '0;
            skid_valid_reg   <= 1'b0;
            skid_last_reg    <= 1'b0;
        end else begin
            done_reg         <= 1'b0;
            read_pending_reg <= read_en;

            if (push) begin
                cap_idx_reg <= cap_idx_reg + CNT_ONE;
            end

            if (pop) begin
                if (skid_valid_reg) begin
                    out_data_reg   <= skid_data_reg;
                    out_last_reg   <= skid_last_reg;
                    skid_valid_reg <= push;
                    if (push) begin
                        skid_data_reg <= fifo_rdata;
                        skid_last_reg <= cap_last;
                    end
                end else if (push) begin
                    out_data_reg <= fifo_rdata;
                    out_last_reg <= cap_last;
                end else begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end else if (push) begin
                if (!out_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= fifo_rdata;
                    out_last_reg  <= cap_last;
                end else begin
                    skid_valid_reg <= 1'b1;
                    skid_data_reg  <= fifo_rdata;
                    skid_last_reg  <= cap_last;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (pkt_words != CNT_ZERO) begin
                            pkt_len_reg    <= pkt_words;
                            reads_left_reg <= pkt_words;
                            cap_idx_reg    <= '0;
                            busy_reg       <= 1'b1;
                            state_reg      <= STREAM;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (read_en) begin
                        reads_left_reg <= reads_left_reg - CNT_ONE;
                        if (reads_left_reg == CNT_ONE) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
